debug_mem_dumper: RTL and testbench
===================================

Name: debug_mem_dumper

Overview:
- Debug-side reader of the data memory's debug read port.
- On a start pulse, walks every memory cell from address 0 to CELDAS-1 and captures each word.
- Serialises each word into bytes and streams them over a valid/ready byte interface to the debug UART transmitter.
- Sits between the data memory debug port and the debug unit's TX path; does not touch the CPU-side ALU address, write or read paths.

Parameters:
- NBITS, 32, word width of memory data and address; must be a multiple of 8.
- CELDAS, 16, number of memory cells to dump; addresses 0..CELDAS-1.

Ports:
- i_clk  input  1  system clock; all state updates on posedge.
- i_reset  input  1  synchronous, active-low reset (0 = reset), sampled on posedge i_clk.
- i_Start  input  1  dump request; sampled only in IDLE.
- o_DebugDireccion  output  NBITS  address driven to the memory debug read port.
- i_DebugDato  input  NBITS  word returned by the memory debug read port; combinational from address.
- o_TxDato  output  8  byte offered to the transmitter.
- o_TxValid  output  1  o_TxDato is valid.
- i_TxReady  input  1  transmitter accepts the byte this cycle.
- o_Busy  output  1  dump in progress (any state other than IDLE).
- o_Done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (i_reset=0 at posedge):
  - state=IDLE; o_DebugDireccion=0; o_TxDato=0; o_TxValid=0; o_Busy=0; o_Done=0.
  - Internal byte counter and shift register cleared.
  - Reset overrides everything, including mid-dump; no partial state survives.
- States: IDLE, SET_ADDR, SEND, DONE.
- IDLE:
  - o_Busy=0.
  - i_Start=1 at edge k → SET_ADDR, o_DebugDireccion=0.
- SET_ADDR: one settle cycle for the debug read path.
  - At the next edge, i_DebugDato is latched into the NBITS shift register, byte counter=0, o_TxValid=1, go SEND.
- SEND:
  - o_TxDato is always the MS byte of the shift register; bytes go MSB first.
  - Transfer occurs on an edge where o_TxValid=1 and i_TxReady=1. On transfer, shift left 8 and increment the byte counter.
  - While i_TxReady=0, o_TxDato and o_TxValid stay stable; there is no timeout.
  - After byte NBITS/8-1 transfers:
    - if address < CELDAS-1: address+1, o_TxValid=0, go SET_ADDR;
    - else: o_TxValid=0, go DONE.
- DONE: o_Done=1 for exactly one cycle, then IDLE. Address returns to 0.
- Snapshot rule: each word is latched once. Memory writes during its serialisation do not affect bytes already latched.
- i_Start while o_Busy=1 is ignored; it is not queued.
- i_Start held high through DONE starts a new dump only after IDLE is re-entered.
- Latency with i_TxReady held at 1, start sampled at edge k:
  - o_TxValid=1 after edge k+1.
  - Word n transfers at edges k+2+5n .. k+5+5n.
  - Last transfer at edge k+5·CELDAS (k+80 with defaults).
  - o_Done high in the following cycle; IDLE after edge k+5·CELDAS+1.
- Address width: the counter wraps-free; it never exceeds CELDAS-1. Upper bits of o_DebugDireccion are zero.

Test Plan:
- Full dump, ready=1, memory model word[i]=32'hCAFE0000|i, start pulse at edge k → 64 bytes CA FE 00 00, CA FE 00 01 … CA FE 00 0F; o_Done single pulse in cycle after edge k+80; o_Busy high from k+1 to the DONE cycle.
- Backpressure: i_TxReady toggles 1/0 pseudo-randomly → identical 64-byte sequence; o_TxDato/o_TxValid never change while valid=1 and ready=0; no byte duplicated or lost.
- Start while busy: second i_Start pulse at byte 10 → exactly 64 bytes and one o_Done. Then i_Start held high for 200 cycles → dumps repeat back-to-back, each separated by the DONE cycle.
- Reset mid-dump: assert i_reset=0 for one cycle during word 5 → next cycle all outputs 0, state IDLE. A new start dumps from address 0 with the full 64 bytes.
- Snapshot: model changes word[3] to 32'h12345678 while byte 1 of word 3 is stalled (ready=0) → bytes sent are CA FE 00 03. On a fresh dump, word 3 sends 12 34 56 78.
- Address sequencing: monitor o_DebugDireccion → takes values 0..15 in order, each held through its SET_ADDR and SEND cycles, returns to 0 after DONE.

Source files
------------

// File: rtl/debug_mem_dumper.sv
// -----------------------------------------------------------------------------
// debug_mem_dumper
//
// Purpose:
//   Debug-side reader of the data memory's debug read port. On a start pulse
//   it walks every cell from address 0 to CELDAS-1. For each cell it latches
//   the word once, then streams it MSB byte first over a valid/ready byte
//   interface toward the debug UART transmitter. It never touches the CPU-side
//   address, write or read paths.
//
// Ports:
//   i_clk            system clock, all state changes on posedge
//   i_reset          synchronous active-low reset (0 = reset)
//   i_Start          dump request, only honoured in IDLE
//   o_DebugDireccion address presented to the memory debug read port
//   i_DebugDato      word from the debug read port (combinational from address)
//   o_TxDato         byte offered to the transmitter (MS byte of the snapshot)
//   o_TxValid        o_TxDato is valid
//   i_TxReady        transmitter accepts the byte this cycle
//   o_Busy           dump in progress (state other than IDLE)
//   o_Done           one-cycle pulse after the last byte is accepted
// -----------------------------------------------------------------------------
module debug_mem_dumper #(
  parameter int NBITS  = 32,
  parameter int CELDAS = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_Start,
  output logic [NBITS-1:0] o_DebugDireccion,
  input  logic [NBITS-1:0] i_DebugDato,
  output logic [7:0]       o_TxDato,
  output logic             o_TxValid,
  input  logic             i_TxReady,
  output logic             o_Busy,
  output logic             o_Done
);

  localparam int NBYTES = NBITS / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELDAS - 1);
  localparam logic [NBITS-1:0] ADDR_ONE  = NBITS'(1);

  typedef enum logic [1:0] {
    IDLE,
    SET_ADDR,
    SEND,
    DONE
  } state_t;

  state_t           state;
  logic [NBITS-1:0] shreg;
  logic [CNT_W-1:0] byte_cnt;

  // The outgoing byte is always the top byte of the snapshot register, so it
  // cannot move while the transmitter stalls: shreg only shifts on a transfer.
  assign o_TxDato = shreg[NBITS-1 -: 8];

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state            <= IDLE;
      o_DebugDireccion <= '0;
      shreg            <= '0;
      byte_cnt         <= '0;
      o_TxValid        <= 1'b0;
      o_Busy           <= 1'b0;
      o_Done           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Start) begin
            state            <= SET_ADDR;
            o_DebugDireccion <= '0;
            o_Busy           <= 1'b1;
          end
        end

        // One settle cycle for the debug read path, then take the snapshot.
        // Later memory writes cannot reach bytes already in shreg.
        SET_ADDR: begin
          shreg     <= i_DebugDato;
          byte_cnt  <= '0;
          o_TxValid <= 1'b1;
          state     <= SEND;
        end

        SEND: begin
          if (o_TxValid && i_TxReady) begin
            shreg    <= shreg << 8;
            byte_cnt <= byte_cnt + CNT_ONE;
            if (byte_cnt == LAST_BYTE) begin
              o_TxValid <= 1'b0;
              if (o_DebugDireccion < LAST_ADDR) begin
                o_DebugDireccion <= o_DebugDireccion + ADDR_ONE;
                state            <= SET_ADDR;
              end else begin
                o_Done <= 1'b1;
                state  <= DONE;
              end
            end
          end
        end

        // i_Start is not looked at here, so a held start only relaunches
        // after IDLE has been re-entered.
        DONE: begin
          o_Done           <= 1'b0;
          o_Busy           <= 1'b0;
          o_DebugDireccion <= '0;
          state            <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_mem_dumper.sv
// -----------------------------------------------------------------------------
// tb_debug_mem_dumper
//
// Scoreboard bench for debug_mem_dumper. Each accepted dump pushes its
// expected 4*CELDAS bytes; a negedge monitor pops and compares every byte the
// DUT hands over, and also watches stall stability, o_Done pulses and the
// address sequence.
// -----------------------------------------------------------------------------
module tb_debug_mem_dumper;

  localparam int NBITS  = 32;
  localparam int CELDAS = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             ready;
  logic             ready_force = 1'b1;
  logic             bp_mode = 1'b0;
  logic             rnd = 1'b1;
  logic [NBITS-1:0] addr;
  logic [NBITS-1:0] dato;
  logic [7:0]       txd;
  logic             txv;
  logic             busy;
  logic             done;

  logic [31:0] mem [CELDAS];

  always #5 clk = ~clk;

  assign dato  = mem[addr[3:0]];
  assign ready = bp_mode ? rnd : ready_force;

  always @(posedge clk) begin
    #1 rnd = 1'($urandom_range(0, 1));
  end

  debug_mem_dumper #(.NBITS(NBITS), .CELDAS(CELDAS)) dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_Start          (start),
    .o_DebugDireccion (addr),
    .i_DebugDato      (dato),
    .o_TxDato         (txd),
    .o_TxValid        (txv),
    .i_TxReady        (ready),
    .o_Busy           (busy),
    .o_Done           (done)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];
  int popped   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int exp_done = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: at the negedge, valid&ready with reset released means the next
  // posedge transfers this byte.
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_dat   = 8'h00;
  logic        prev_done  = 1'b0;
  logic [31:0] prev_addr  = 32'h0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid", {31'h0, txv}, 32'h1);
        check("stall_data", {24'h0, txd}, {24'h0, prev_dat});
      end
      if (txv && ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_byte: got %h expected none", txd);
        end else begin
          check("byte", {24'h0, txd}, {24'h0, sb.pop_front()});
          popped++;
        end
      end
      prev_stall = txv && !ready;
      prev_dat   = txd;
      if (done) begin
        check("done_single", {31'h0, prev_done}, 32'h0);
        done_cnt++;
        done_cyc = cyc;
      end
      prev_done = done;
      if (addr != prev_addr) begin
        if (addr == 32'h0)
          check("addr_wrap_from", prev_addr, CELDAS - 1);
        else
          check("addr_step", addr, prev_addr + 32'h1);
      end
      prev_addr = addr;
    end else begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      prev_addr  = 32'h0;
    end
  end

  task automatic push_dump();
    for (int i = 0; i < CELDAS; i++) begin
      sb.push_back(mem[i][31:24]);
      sb.push_back(mem[i][23:16]);
      sb.push_back(mem[i][15:8]);
      sb.push_back(mem[i][7:0]);
    end
  endtask

  // Returns #1 after the edge that samples start high (edge k).
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(posedge clk);
    check("done_count", done_cnt, target);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_popped(input int target, input int budget);
    for (int i = 0; i < budget && popped < target; i++) begin
      @(posedge clk); #1;
    end
    check("popped_reach", {31'h0, popped >= target}, 32'h1);
  endtask

  int k_cyc;
  int base;

  initial begin
    for (int i = 0; i < CELDAS; i++) mem[i] = 32'hCAFE_0000 | i;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'h0, txv}, 32'h0);
    check("rst_data", {24'h0, txd}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_addr", addr, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full dump with ready=1, latency checks
    ready_force = 1'b1;
    push_dump();
    exp_done++;
    pulse_start();
    k_cyc = cyc;
    check("k_busy", {31'h0, busy}, 32'h1);
    check("k_valid", {31'h0, txv}, 32'h0);
    check("k_addr", addr, 32'h0);
    @(posedge clk); #1;
    check("k1_valid", {31'h0, txv}, 32'h1);
    check("k1_data", {24'h0, txd}, 32'hCA);
    wait_done(exp_done, 200);
    check("done_latency", done_cyc - k_cyc, 80);
    check("post_busy", {31'h0, busy}, 32'h0);
    check("post_addr", addr, 32'h0);

    // Backpressure
    bp_mode = 1'b1;
    push_dump();
    exp_done++;
    pulse_start();
    wait_done(exp_done, 2000);
    bp_mode = 1'b0;

    // Second start while busy is ignored
    base = popped;
    push_dump();
    exp_done++;
    pulse_start();
    wait_popped(base + 10, 100);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(exp_done, 300);
    check("busy_start_bytes", popped - base, 64);

    // Start held for 200 edges: accepted at relative edges 0, 82, 164
    base = popped;
    push_dump(); push_dump(); push_dump();
    exp_done += 3;
    start = 1'b1;
    repeat (200) @(posedge clk);
    #1 start = 1'b0;
    wait_done(exp_done, 400);
    check("held_bytes", popped - base, 192);

    // Snapshot: change word 3 while its byte 1 is stalled
    base = popped;
    push_dump();
    exp_done++;
    pulse_start();
    wait_popped(base + 13, 200);
    ready_force = 1'b0;
    mem[3] = 32'h1234_5678;
    repeat (5) @(posedge clk);
    #1 ready_force = 1'b1;
    wait_done(exp_done, 300);
    base = popped;
    push_dump();
    exp_done++;
    pulse_start();
    wait_done(exp_done, 300);
    check("snap_fresh_bytes", popped - base, 64);

    // Reset during word 5, then a complete dump from address 0
    base = popped;
    push_dump();
    pulse_start();
    wait_popped(base + 22, 200);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check("mid_rst_valid", {31'h0, txv}, 32'h0);
    check("mid_rst_data", {24'h0, txd}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_done", {31'h0, done}, 32'h0);
    check("mid_rst_addr", addr, 32'h0);
    sb.delete();
    @(posedge clk); #1;
    base = popped;
    push_dump();
    exp_done++;
    pulse_start();
    wait_done(exp_done, 300);
    check("after_rst_bytes", popped - base, 64);

    check("sb_empty", sb.size(), 0);
    check("done_total", done_cnt, exp_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
